// File: rtl/countdown_timer_ctrl_if.sv
// Control/status bundle between a countdown timer and the logic that drives it.
// The master issues commands; the slave (the timer) reports state and pulses.
interface countdown_timer_ctrl_if #(
  parameter int WIDTH = 20
);
  logic             start;
  logic [WIDTH-1:0] duration_ms;
  logic             pause;
  logic             resume;
  logic             cancel;
  logic [1:0]       state;
  logic             busy;
  logic [WIDTH-1:0] remaining_ms;
  logic             ms_tick;
  logic             sec_tick;
  logic             done;

  modport master (
    output start, duration_ms, pause, resume, cancel,
    input  state, busy, remaining_ms, ms_tick, sec_tick, done
  );

  modport slave (
    input  start, duration_ms, pause, resume, cancel,
    output state, busy, remaining_ms, ms_tick, sec_tick, done
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Programmable countdown timer: a ms prescaler produces single-cycle enable ticks
// in the clk domain, with start/pause/resume/cancel control and a done pulse.
module countdown_timer_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int MS_PER_S = 1000,
  parameter int WIDTH    = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  countdown_timer_ctrl_if.slave bus
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int CNT_W = $clog2(MS_PER_S);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MS_PER_S - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ms_tick_q, ms_tick_d;
  logic             sec_tick_q, sec_tick_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      pre_q      <= '0;
      cnt_q      <= '0;
      ms_tick_q  <= 1'b0;
      sec_tick_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      ms_tick_q  <= ms_tick_d;
      sec_tick_q <= sec_tick_d;
      done_q     <= done_d;
    end
  end

  // Commands are resolved in priority order cancel > start > pause > resume;
  // pause beats counting, so a partial ms is kept exactly where it stopped.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    ms_tick_d  = 1'b0;
    sec_tick_d = 1'b0;
    done_d     = 1'b0;

    if (bus.cancel) begin
      state_d = IDLE;
      rem_d   = '0;
      pre_d   = '0;
      cnt_d   = '0;
    end else if (bus.start) begin
      pre_d = '0;
      cnt_d = '0;
      if (bus.duration_ms != '0) begin
        state_d = RUNNING;
        rem_d   = bus.duration_ms;
      end else begin
        state_d = EXPIRED;
        rem_d   = '0;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        RUNNING: begin
          if (bus.pause) begin
            state_d = PAUSED;
          end else if (pre_q == PRE_LAST) begin
            pre_d     = '0;
            ms_tick_d = 1'b1;
            rem_d     = rem_q - WIDTH'(1);
            if (cnt_q == CNT_LAST) begin
              cnt_d      = '0;
              sec_tick_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (rem_q == WIDTH'(1)) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        PAUSED: begin
          if (!bus.pause && bus.resume) begin
            state_d = RUNNING;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.busy         = (state_q == RUNNING) || (state_q == PAUSED);
  assign bus.remaining_ms = rem_q;
  assign bus.ms_tick      = ms_tick_q;
  assign bus.sec_tick     = sec_tick_q;
  assign bus.done         = done_q;

endmodule
